// File: rtl/alu_uart_if.sv
// alu_uart_if: serial command sequencer in front of the 8-bit ALU.
// It collects three UART bytes (A, B, opcode) and drives them to the ALU
// as registered values. It then transmits the ALU result, followed by the
// flags byte when ALU_UART_FLAGS_EN is defined. If the link stalls in the
// middle of a frame, an inter-byte timeout resynchronises the sequencer.
// Build option: `define ALU_UART_FLAGS_EN to send the flags byte after the result.
module alu_uart_if #(
    parameter int W       = 8,
    parameter int WOP     = 6,
    parameter int TIMEOUT = 100000
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [W-1:0]   rx_data_i,
    input  logic           rx_done_i,
    output logic [W-1:0]   tx_data_o,
    output logic           tx_start_o,
    input  logic           tx_done_i,
    output logic [W-1:0]   alu_a_o,
    output logic [W-1:0]   alu_b_o,
    output logic [WOP-1:0] alu_op_o,
    input  logic [W-1:0]   alu_y_i,
    input  logic [4:0]     alu_flags_i,
    output logic           busy_o,
    output logic           frame_err_o
);

    localparam int            CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_EXEC,
        S_SEND_Y,
`ifdef ALU_UART_FLAGS_EN
        S_WAIT_Y,
        S_SEND_F,
        S_WAIT_F
`else
        S_WAIT_Y
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [WOP-1:0]  op_q, op_d;
    // tx_data_q also acts as the captured result register.
    logic [W-1:0]    tx_data_q, tx_data_d;
    logic            busy_q, busy_d;
    logic            fe_q, fe_d;
    logic [CW-1:0]   cnt_q, cnt_d;
`ifdef ALU_UART_FLAGS_EN
    logic [4:0]      flg_q, flg_d;
`else
    logic            unused_flags;
    assign unused_flags = ^alu_flags_i;
`endif

    // Next-state and datapath update for the frame sequencer
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        tx_data_d = tx_data_q;
        busy_d    = busy_q;
        fe_d      = 1'b0;
        cnt_d     = cnt_q;
`ifdef ALU_UART_FLAGS_EN
        flg_d     = flg_q;
`endif
        case (state_q)
            S_WAIT_A: begin
                cnt_d = '0;
                if (rx_done_i) begin
                    a_d     = rx_data_i;
                    state_d = S_WAIT_B;
                end
            end
            S_WAIT_B, S_WAIT_OP: begin
                if (rx_done_i) begin
                    // A byte arriving on the expiry cycle still wins.
                    cnt_d = '0;
                    if (state_q == S_WAIT_B) begin
                        b_d     = rx_data_i;
                        state_d = S_WAIT_OP;
                    end else begin
                        op_d    = rx_data_i[WOP-1:0];
                        busy_d  = 1'b1;
                        state_d = S_EXEC;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    // Partial operands are kept; only the frame position resets.
                    cnt_d   = '0;
                    fe_d    = 1'b1;
                    state_d = S_WAIT_A;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_EXEC: begin
                tx_data_d = alu_y_i;
`ifdef ALU_UART_FLAGS_EN
                flg_d     = alu_flags_i;
`endif
                state_d   = S_SEND_Y;
            end
            S_SEND_Y: begin
                state_d = S_WAIT_Y;
            end
            S_WAIT_Y: begin
                if (tx_done_i) begin
`ifdef ALU_UART_FLAGS_EN
                    tx_data_d = {{(W-5){1'b0}}, flg_q};
                    state_d   = S_SEND_F;
`else
                    busy_d    = 1'b0;
                    state_d   = S_WAIT_A;
`endif
                end
            end
`ifdef ALU_UART_FLAGS_EN
            S_SEND_F: begin
                state_d = S_WAIT_F;
            end
            S_WAIT_F: begin
                if (tx_done_i) begin
                    busy_d  = 1'b0;
                    state_d = S_WAIT_A;
                end
            end
`endif
            default: begin
                state_d = S_WAIT_A;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame or transmission
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_WAIT_A;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            tx_data_q <= '0;
            busy_q    <= 1'b0;
            fe_q      <= 1'b0;
            cnt_q     <= '0;
`ifdef ALU_UART_FLAGS_EN
            flg_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            tx_data_q <= tx_data_d;
            busy_q    <= busy_d;
            fe_q      <= fe_d;
            cnt_q     <= cnt_d;
`ifdef ALU_UART_FLAGS_EN
            flg_q     <= flg_d;
`endif
        end
    end

    // Each send state lasts exactly one cycle, so tx_start is a single-cycle strobe.
`ifdef ALU_UART_FLAGS_EN
    assign tx_start_o  = (state_q == S_SEND_Y) || (state_q == S_SEND_F);
`else
    assign tx_start_o  = (state_q == S_SEND_Y);
`endif
    assign tx_data_o   = tx_data_q;
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign alu_op_o    = op_q;
    assign busy_o      = busy_q;
    assign frame_err_o = fe_q;

endmodule

// File: tb/tb_alu_uart_if.sv
// Bench for alu_uart_if. It contains a behavioural ALU, a UART transmitter
// responder that raises tx_done 10 cycles after tx_start, and a reference
// model of the command frame. Stimulus uses directed and random frames.
module tb_alu_uart_if;
    localparam int W = 8, WOP = 6, TO = 16, TXD = 10;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b1;
    logic [W-1:0]   rx_data_i = '0;
    logic           rx_done_i = 1'b0;
    logic [W-1:0]   tx_data_o;
    logic           tx_start_o;
    logic           tx_done_i = 1'b0;
    logic [W-1:0]   alu_a_o, alu_b_o;
    logic [WOP-1:0] alu_op_o;
    logic [W-1:0]   alu_y_i;
    logic [4:0]     alu_flags_i;
    logic           busy_o, frame_err_o;

    alu_uart_if #(.W(W), .WOP(WOP), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rx_data_i(rx_data_i), .rx_done_i(rx_done_i),
        .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .tx_done_i(tx_done_i),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
        .alu_y_i(alu_y_i), .alu_flags_i(alu_flags_i),
        .busy_o(busy_o), .frame_err_o(frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct { int c; logic [W-1:0] d; } ev_t;
    ev_t  st_q[$];
    int   fe_q[$];
    int   last_done = -1;
    int   n_done = 0;
    int   errs = 0, checks = 0;
    logic [W-1:0]   m_a = '0, m_b = '0;
    logic [WOP-1:0] m_op = '0;

    // Behavioural ALU: returns {carry, borrow, overflow, zero, neg, y}.
    function automatic logic [12:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [5:0] op);
        logic [8:0] s;
        logic [7:0] y;
        logic c, bw, ov;
        c = 1'b0; bw = 1'b0; ov = 1'b0; y = 8'h00;
        case (op)
            6'h20: begin
                s  = {1'b0, a} + {1'b0, b};
                y  = s[7:0];
                c  = s[8];
                ov = (a[7] == b[7]) && (y[7] != a[7]);
            end
            6'h22: begin
                y  = a - b;
                bw = (a < b);
                ov = (a[7] != b[7]) && (y[7] != a[7]);
            end
            6'h24: y = a & b;
            6'h25: y = a | b;
            6'h26: y = a ^ b;
            default: y = 8'h00;
        endcase
        // neg is the sign of the true (unwrapped) result.
        return {c, bw, ov, (y == 8'h00), y[7] ^ ov, y};
    endfunction

    assign {alu_flags_i, alu_y_i} = alu_ref(alu_a_o, alu_b_o, alu_op_o);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor and transmitter responder, sampled 1 time unit after each edge
    logic prev_st = 1'b0, prev_fe = 1'b0;
    int   cd = 0;
    always @(posedge clk_i) begin
        #1;
        if (!rst_ni) begin
            prev_st = 1'b0; prev_fe = 1'b0; cd = 0; tx_done_i = 1'b0;
        end else begin
            if (tx_start_o) begin
                chk("tx_start_width", {31'd0, prev_st}, 0);
                st_q.push_back('{cyc, tx_data_o});
            end
            if (frame_err_o) begin
                chk("frame_err_width", {31'd0, prev_fe}, 0);
                fe_q.push_back(cyc);
            end
            prev_st = tx_start_o;
            prev_fe = frame_err_o;
            tx_done_i = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    tx_done_i = 1'b1;
                    last_done = cyc;
                    n_done++;
                end
            end
            if (tx_start_o) cd = TXD;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send(input logic [7:0] b, output int c);
        rx_data_i = b;
        rx_done_i = 1'b1;
        c = cyc;
        @(negedge clk_i);
        rx_done_i = 1'b0;
        rx_data_i = 8'($urandom);
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (st_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        chk("tx_start_seen", {31'd0, ok}, 1);
    endtask

    // One full command frame with optional inter-byte gaps and optional junk bytes during WAIT_Y
    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input int g1, input int g2, input bit inj);
        int c, dmy, d0, nb;
        bit ok, got;
        ev_t e;
        logic [12:0] r;
        send(a, c); idle(g1);
        send(b, c); idle(g2);
        chk("busy_pre", {31'd0, busy_o}, 0);
        d0 = n_done;
        send(opb, c);
        m_a = a; m_b = b; m_op = opb[5:0];
        r = alu_ref(m_a, m_b, m_op);
        chk("busy_exec", {31'd0, busy_o}, 1);
        chk("alu_a", alu_a_o, m_a);
        chk("alu_b", alu_b_o, m_b);
        chk("alu_op", alu_op_o, m_op);
        wait_start(ok);
        if (ok) begin
            e = st_q.pop_front();
            chk("y_latency", e.c - c, 2);
            chk("y_data", e.d, r[7:0]);
        end
        if (inj) begin
            idle(2);
            for (int i = 0; i < 3; i++) send(8'($urandom), dmy);
        end
        nb = 1;
`ifdef ALU_UART_FLAGS_EN
        nb = 2;
        wait_start(ok);
        if (ok) begin
            e = st_q.pop_front();
            chk("f_gap", e.c - last_done, 1);
            chk("f_data", e.d, {3'b000, r[12:8]});
        end
`endif
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (n_done == d0 + nb) begin
                got = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        chk("tx_done_seen", {31'd0, got}, 1);
        chk("busy_last_done", {31'd0, busy_o}, 1);
        @(negedge clk_i);
        chk("busy_fall", {31'd0, busy_o}, 0);
        chk("hold_a", alu_a_o, m_a);
        chk("hold_b", alu_b_o, m_b);
        chk("hold_op", alu_op_o, m_op);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_a"}, alu_a_o, 0);
        chk({tag, "_b"}, alu_b_o, 0);
        chk({tag, "_op"}, alu_op_o, 0);
        chk({tag, "_txd"}, tx_data_o, 0);
        chk({tag, "_txs"}, {31'd0, tx_start_o}, 0);
        chk({tag, "_busy"}, {31'd0, busy_o}, 0);
        chk({tag, "_ferr"}, {31'd0, frame_err_o}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bit ok;
        logic [5:0] ops [5];
        logic [7:0] opb;
        ev_t e;
        ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};

        #2 rst_ni = 1'b0;
        idle(3);
        chk_reset_outs("rst");
        rst_ni = 1'b1;
        idle(2);

        // Directed frames: ADD, overflow, SUB to zero
        frame(8'h05, 8'h03, 8'h20, 0, 0, 1'b0);
        frame(8'h7F, 8'h01, 8'h20, 0, 0, 1'b0);
        frame(8'h05, 8'h05, 8'h22, 0, 0, 1'b0);
        // Opcode masking with bytes dropped during WAIT_Y, then a clean frame
        frame(8'h09, 8'h04, 8'hE0, 1, 2, 1'b1);
        chk("no_stray_start", st_q.size(), 0);
        frame(8'h01, 8'h01, 8'h20, 0, 0, 1'b0);

        // Timeout after a lone A byte
        send(8'hAA, c);
        idle(20);
        chk("fe_count", fe_q.size(), 1);
        if (fe_q.size() > 0) chk("fe_cycle", fe_q[0] - c, TO + 1);
        chk("to_keep_a", alu_a_o, 8'hAA);
        chk("to_keep_b", alu_b_o, m_b);
        chk("to_busy", {31'd0, busy_o}, 0);
        chk("to_no_start", st_q.size(), 0);
        fe_q.delete();
        frame(8'h10, 8'h20, 8'h20, 0, 0, 1'b0);
        // Bytes exactly on the expiry cycle are accepted
        frame(8'h21, 8'h13, 8'h22, TO - 1, TO - 1, 1'b0);
        chk("expiry_no_fe", fe_q.size(), 0);
        // One cycle later the byte starts a new frame instead
        send(8'h33, c);
        idle(TO);
        frame(8'h44, 8'h06, 8'h20, 0, 0, 1'b0);
        chk("late_fe_count", fe_q.size(), 1);
        if (fe_q.size() > 0) chk("late_fe_cycle", fe_q[0] - c, TO + 1);
        fe_q.delete();

        // Random frames
        repeat (12) begin
            opb = {2'($urandom), ops[$urandom_range(0, 4)]};
            if ($urandom_range(0, 5) == 0) opb = 8'($urandom);
            frame(8'($urandom), 8'($urandom), opb,
                  $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), 1'($urandom));
        end
        chk("rand_no_fe", fe_q.size(), 0);

        // Reset while waiting for the transmitter
        send(8'h11, c);
        send(8'h22, c);
        send(8'h20, c);
        wait_start(ok);
        if (ok) e = st_q.pop_front();
        idle(3);
        rst_ni = 1'b0;
        #1;
        chk_reset_outs("async_rst");
        idle(3);
        rst_ni = 1'b1;
        m_a = '0; m_b = '0; m_op = '0;
        idle(25);
        chk("rst_no_start", st_q.size(), 0);
        chk("rst_no_fe", fe_q.size(), 0);
        frame(8'h02, 8'h02, 8'h20, 0, 0, 1'b0);

        chk("end_no_start", st_q.size(), 0);
        chk("end_no_fe", fe_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
